// File: rtl/audio_frame_buffer.sv
// rtl/audio_frame_buffer.sv - sample-rate capture into ping-pong frame banks, streamed out over valid/ready
module audio_frame_buffer #(
    parameter int CLK_DIV   = 25000,
    parameter int FRAME_LEN = 64,
    parameter int OUT_W     = 24
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [31:0]                  sample_in,
    output logic                         frame_valid,
    input  logic                         rd_ready,
    output logic [OUT_W-1:0]             rd_data,
    output logic [$clog2(FRAME_LEN)-1:0] rd_index,
    output logic                         rd_last,
    output logic [OUT_W-1:0]             frame_peak,
    output logic                         overrun,
    output logic [7:0]                   overrun_count
);

    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);
    localparam logic [OUT_W-1:0] S_MIN    = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] S_MAX    = {1'b0, {(OUT_W-1){1'b1}}};

    typedef enum logic {ST_IDLE, ST_STREAM} rd_state_t;

    rd_state_t        state_q, state_d;
    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [IDX_W-1:0] rd_index_q, rd_index_d;
    logic             wr_bank_q, wr_bank_d;
    logic [OUT_W-1:0] run_peak_q, run_peak_d;
    logic [OUT_W-1:0] frame_peak_q, frame_peak_d;
    logic             overrun_q, overrun_d;
    logic [7:0]       ovr_cnt_q, ovr_cnt_d;

    logic [OUT_W-1:0] bank_mem [2][FRAME_LEN];

    logic             tick;
    logic [OUT_W-1:0] s;
    logic [OUT_W-1:0] s_abs;
    logic [OUT_W-1:0] peak_next;
    logic             frame_done;
    logic             last_xfer;
    logic             swap;
    logic             rd_bank;
    logic             unused_sample_bits;

    assign unused_sample_bits = ^sample_in;

    always_comb begin
        tick       = (tick_cnt_q == '0);
        tick_cnt_d = tick ? CNT_LOAD : tick_cnt_q - 1'b1;
        s          = sample_in[31 -: OUT_W];

        // The most-negative sample has no positive twin; clamp instead of wrapping.
        if (s == S_MIN) begin
            s_abs = S_MAX;
        end else if (s[OUT_W-1]) begin
            s_abs = -s;
        end else begin
            s_abs = s;
        end

        peak_next  = ((wr_ptr_q == '0) || (s_abs > run_peak_q)) ? s_abs : run_peak_q;
        frame_done = tick && (wr_ptr_q == IDX_LAST);
        last_xfer  = (state_q == ST_STREAM) && rd_ready && (rd_index_q == IDX_LAST);
        swap       = frame_done && ((state_q == ST_IDLE) || last_xfer);

        wr_ptr_d     = tick ? wr_ptr_q + 1'b1 : wr_ptr_q;
        run_peak_d   = tick ? peak_next : run_peak_q;
        wr_bank_d    = swap ? ~wr_bank_q : wr_bank_q;
        frame_peak_d = swap ? peak_next : frame_peak_q;

        overrun_d = overrun_q;
        ovr_cnt_d = ovr_cnt_q;
        if (frame_done && !swap) begin
            overrun_d = 1'b1;
            if (ovr_cnt_q != 8'hFF) begin
                ovr_cnt_d = ovr_cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rd_index_d = rd_index_q;
        case (state_q)
            ST_IDLE: begin
                if (swap) begin
                    state_d    = ST_STREAM;
                    rd_index_d = '0;
                end
            end
            ST_STREAM: begin
                if (rd_ready) begin
                    // Index wraps to 0 after the last sample, ready for the next frame.
                    rd_index_d = rd_index_q + 1'b1;
                    if (rd_index_q == IDX_LAST) begin
                        state_d = swap ? ST_STREAM : ST_IDLE;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                rd_index_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            tick_cnt_q   <= CNT_LOAD;
            wr_ptr_q     <= '0;
            rd_index_q   <= '0;
            wr_bank_q    <= 1'b0;
            run_peak_q   <= '0;
            frame_peak_q <= '0;
            overrun_q    <= 1'b0;
            ovr_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_index_q   <= rd_index_d;
            wr_bank_q    <= wr_bank_d;
            run_peak_q   <= run_peak_d;
            frame_peak_q <= frame_peak_d;
            overrun_q    <= overrun_d;
            ovr_cnt_q    <= ovr_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tick) begin
            bank_mem[wr_bank_q][wr_ptr_q] <= s;
        end
    end

    assign rd_bank       = ~wr_bank_q;
    assign frame_valid   = (state_q == ST_STREAM);
    assign rd_index      = frame_valid ? rd_index_q : '0;
    assign rd_data       = frame_valid ? bank_mem[rd_bank][rd_index_q] : '0;
    assign rd_last       = frame_valid && (rd_index_q == IDX_LAST);
    assign frame_peak    = frame_peak_q;
    assign overrun       = overrun_q;
    assign overrun_count = ovr_cnt_q;

endmodule

// File: tb/tb_audio_frame_buffer.sv
// tb/tb_audio_frame_buffer.sv - directed bench for audio_frame_buffer with a frame-level reference model
module tb_audio_frame_buffer;

    localparam int CLK_DIV = 4;
    localparam int FL      = 8;
    localparam int OW      = 24;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rd_ready = 1'b0;
    logic [31:0]   sample_in = '0;
    logic          frame_valid;
    logic [OW-1:0] rd_data;
    logic [2:0]    rd_index;
    logic          rd_last;
    logic [OW-1:0] frame_peak;
    logic          overrun;
    logic [7:0]    overrun_count;

    audio_frame_buffer #(.CLK_DIV(CLK_DIV), .FRAME_LEN(FL), .OUT_W(OW)) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_in     (sample_in),
        .frame_valid   (frame_valid),
        .rd_ready      (rd_ready),
        .rd_data       (rd_data),
        .rd_index      (rd_index),
        .rd_last       (rd_last),
        .frame_peak    (frame_peak),
        .overrun       (overrun),
        .overrun_count (overrun_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    // Reference model: frames are whole arrays, the consumer side is "a frame is on offer at index idx".
    int          m_ecount, m_wcount, m_frames, m_wpeak, m_idx, m_peak, m_ocnt;
    bit          m_valid, m_ovr;
    logic [23:0] m_wbuf [FL];
    logic [23:0] m_rbuf [FL];
    logic [31:0] pat [4][FL];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int mag(input logic [31:0] x);
        logic signed [23:0] t;
        int v;
        t = x[31:8];
        v = t;
        if (v < 0) v = -v;
        if (v > 8388607) v = 8388607;
        return v;
    endfunction

    task automatic model_reset();
        m_ecount = 0; m_wcount = 0; m_frames = 0; m_wpeak = 0;
        m_valid = 0; m_idx = 0; m_peak = 0; m_ovr = 0; m_ocnt = 0;
    endtask

    task automatic model_step();
        bit tick;
        if (reset) return;
        m_ecount++;
        tick = (m_ecount % CLK_DIV) == 0;
        if (m_valid && rd_ready) begin
            if (m_idx == FL - 1) m_valid = 0;
            else m_idx++;
        end
        if (tick) begin
            m_wbuf[m_wcount] = sample_in[31:8];
            if (m_wcount == 0 || mag(sample_in) > m_wpeak) m_wpeak = mag(sample_in);
            m_wcount++;
            if (m_wcount == FL) begin
                m_wcount = 0;
                m_frames++;
                if (!m_valid) begin
                    m_rbuf  = m_wbuf;
                    m_valid = 1;
                    m_idx   = 0;
                    m_peak  = m_wpeak;
                end else begin
                    m_ovr = 1;
                    if (m_ocnt < 255) m_ocnt++;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("frame_valid", 32'(frame_valid), 32'(m_valid));
                check("rd_index", 32'(rd_index), m_valid ? 32'(m_idx) : 32'd0);
                check("rd_data", 32'(rd_data), m_valid ? 32'(m_rbuf[m_idx]) : 32'd0);
                check("rd_last", 32'(rd_last), 32'(m_valid && m_idx == FL - 1));
                check("frame_peak", 32'(frame_peak), 32'(m_peak));
                check("overrun", 32'(overrun), 32'(m_ovr));
                check("overrun_count", 32'(overrun_count), 32'(m_ocnt));
            end
        end
    end

    // One clock: inputs set for the coming edge, model advanced, then land at negedge+1.
    task automatic cycle(input bit rdy);
        rd_ready  = rdy;
        sample_in = (((m_ecount + 1) % CLK_DIV) == 0) ? pat[m_frames % 4][m_wcount] : $urandom;
        model_step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // mode 0: ready low, 1: high, 2: 1,0,0,1 pattern, 3: high from edge 57 on
    task automatic run_to(input int e_target, input int mode);
        bit rdy;
        int ph;
        while (m_ecount < e_target) begin
            ph = (m_ecount + 1) % 4;
            case (mode)
                0: rdy = 0;
                1: rdy = 1;
                2: rdy = (ph == 1) || (ph == 0);
                default: rdy = (m_ecount + 1) >= 57;
            endcase
            cycle(rdy);
        end
    endtask

    task automatic start();
        reset = 1'b1;
        model_reset();
        cycle(0);
        cycle(0);
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        for (int f = 0; f < 4; f++)
            for (int k = 0; k < FL; k++)
                pat[f][k] = (f == 0) ? (32'(k) << 8) : $urandom;
        @(negedge clk);
        #1;
        chk_en = 1;

        // Reset, idle, ramp frame streamed with rd_ready high
        start();
        check("reset_frame_valid", 32'(frame_valid), 32'd0);
        check("reset_overrun_count", 32'(overrun_count), 32'd0);
        run_to(31, 1);
        check("pre_frame_valid", 32'(frame_valid), 32'd0);
        check("pre_frame_peak", 32'(frame_peak), 32'd0);
        run_to(32, 1);
        check("first_valid", 32'(frame_valid), 32'd1);
        check("first_index", 32'(rd_index), 32'd0);
        check("ramp_peak", 32'(frame_peak), 32'd7);
        run_to(35, 1);
        check("ramp_data3", 32'(rd_data), 32'd3);
        run_to(39, 1);
        check("ramp_last", 32'(rd_last), 32'd1);
        check("ramp_data7", 32'(rd_data), 32'd7);
        run_to(40, 1);
        check("ramp_done", 32'(frame_valid), 32'd0);

        // Backpressure 1,0,0,1 across two further frames
        run_to(110, 2);
        check("bp_no_overrun", 32'(overrun), 32'd0);

        // Overrun: first frame held, later completions discarded
        start();
        run_to(63, 0);
        check("ovr_before", 32'(overrun), 32'd0);
        run_to(64, 0);
        check("ovr_set", 32'(overrun), 32'd1);
        check("ovr_count1", 32'(overrun_count), 32'd1);
        check("ovr_held_idx", 32'(rd_index), 32'd0);
        run_to(96, 0);
        check("ovr_count2", 32'(overrun_count), 32'd2);
        run_to(100, 1);
        check("ovr_intact4", 32'(rd_data), 32'd4);
        check("ovr_peak", 32'(frame_peak), 32'd7);
        run_to(104, 1);
        check("ovr_drained", 32'(frame_valid), 32'd0);
        run_to(130 + 256 * 32, 0);
        check("ovr_saturate", 32'(overrun_count), 32'd255);
        check("ovr_sticky", 32'(overrun), 32'd1);

        // Last transfer coincides with completion tick; most-negative sample
        for (int k = 0; k < FL; k++) pat[1][k] = 32'(k - 4) << 8;
        pat[1][5] = 32'h8000_0000;
        start();
        run_to(63, 3);
        check("bnd_last", 32'(rd_last), 32'd1);
        run_to(64, 3);
        check("bnd_valid", 32'(frame_valid), 32'd1);
        check("bnd_index", 32'(rd_index), 32'd0);
        check("bnd_overrun", 32'(overrun), 32'd0);
        check("bnd_peak", 32'(frame_peak), 32'h7F_FFFF);
        run_to(69, 1);
        check("bnd_minneg", 32'(rd_data), 32'h80_0000);
        run_to(80, 1);

        // Asynchronous reset mid-stream
        start();
        run_to(35, 1);
        check("mid_index3", 32'(rd_index), 32'd3);
        reset = 1'b1;
        model_reset();
        #1;
        check("async_valid", 32'(frame_valid), 32'd0);
        check("async_index", 32'(rd_index), 32'd0);
        check("async_data", 32'(rd_data), 32'd0);
        check("async_peak", 32'(frame_peak), 32'd0);
        @(negedge clk);
        #1;
        cycle(0);
        reset = 1'b0;
        run_to(32, 1);
        check("post_valid", 32'(frame_valid), 32'd1);
        check("post_index", 32'(rd_index), 32'd0);
        check("post_peak", 32'(frame_peak), 32'd7);
        run_to(45, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
